// File: rtl/uart_fifo_arbiter.sv
// Round-robin arbiter sharing the UARTS_Complex command port among per-channel
// one-word holding slots, with inter-grant gap, throttle and sticky overrun flags.

module uart_fifo_arbiter_slot #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stb,
    input  logic [DATA_W-1:0] din,
    input  logic              grant,
    input  logic              clr,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              ovr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ovr   <= 1'b0;
        end else begin
            // a word arriving while its predecessor is leaving takes the slot over
            if (stb && (!valid || grant)) begin
                valid <= 1'b1;
                data  <= din;
            end else if (grant) begin
                valid <= 1'b0;
            end
            if (stb && valid && !grant)
                ovr <= 1'b1;
            else if (clr)
                ovr <= 1'b0;
        end
    end
endmodule

module uart_fifo_arbiter #(
    parameter int CHANNELS = 32,
    parameter int DATA_W   = 10,
    parameter int MIN_GAP  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNELS-1:0]        req_stb,
    input  logic [CHANNELS*DATA_W-1:0] req_data,
    output logic [CHANNELS-1:0]        req_busy,
    input  logic                       throttle,
    output logic                       fifo_cs,
    output logic [31:0]                fifo_data,
    output logic [CHANNELS-1:0]        ovr_flags,
    input  logic [CHANNELS-1:0]        ovr_clr
);
    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic [4:0]        ch;
        logic [DATA_W-1:0] data;
    } grant_t;

    state_t                          state, state_nx;
    logic [CHANNELS-1:0]             slot_valid;
    logic [CHANNELS-1:0][DATA_W-1:0] slot_data;
    logic [CHANNELS-1:0]             grant_vec;
    logic [4:0]                      last, pick, idx;
    logic [3:0]                      gap_cnt;
    logic                            found, grant_now;
    int                              idx_i;
    grant_t                          g;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_slot
            assign grant_vec[i] = grant_now && (pick == 5'(i));
            uart_fifo_arbiter_slot #(.DATA_W(DATA_W)) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .stb   (req_stb[i]),
                .din   (req_data[i*DATA_W +: DATA_W]),
                .grant (grant_vec[i]),
                .clr   (ovr_clr[i]),
                .valid (slot_valid[i]),
                .data  (slot_data[i]),
                .ovr   (ovr_flags[i])
            );
        end
    endgenerate

    assign req_busy = slot_valid;

    // first valid slot after last, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = '0;
        idx_i = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx_i = int'(last) + k;
            if (idx_i >= CHANNELS)
                idx_i = idx_i - CHANNELS;
            idx = idx_i[4:0];
            if (!found && slot_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // a decision may follow a grant directly once the gap counter is empty
    always_comb begin
        grant_now = found && !throttle && (gap_cnt == 4'd0);
        state_nx  = IDLE;
        case (state)
            IDLE:    state_nx = grant_now ? GRANT : IDLE;
            GRANT:   state_nx = grant_now ? GRANT : IDLE;
            default: state_nx = IDLE;
        endcase
        g.ch   = pick;
        g.data = slot_data[pick];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 5'(CHANNELS - 1);
            gap_cnt   <= '0;
            fifo_data <= '0;
        end else begin
            state <= state_nx;
            if (grant_now) begin
                last      <= pick;
                gap_cnt   <= 4'(MIN_GAP);
                fifo_data <= 32'(g);
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    assign fifo_cs = (state == GRANT);
endmodule

// File: tb/tb_uart_fifo_arbiter.sv
// Bench for uart_fifo_arbiter: two instances (MIN_GAP 0 and 3) driven by shared
// stimulus and checked every cycle against a slot/queue level reference model.

module tb_uart_fifo_arbiter;
    logic              clk;
    logic              rst_n;
    logic [31:0]       req_stb;
    logic [319:0]      req_data;
    logic              throttle;
    logic [31:0]       ovr_clr;
    logic [1:0]        cs;
    logic [1:0][31:0]  fd, busy, ovr;

    int n_cmp = 0;
    int n_bad = 0;

    uart_fifo_arbiter #(.CHANNELS(32), .DATA_W(10), .MIN_GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_stb(req_stb), .req_data(req_data),
        .req_busy(busy[0]), .throttle(throttle), .fifo_cs(cs[0]),
        .fifo_data(fd[0]), .ovr_flags(ovr[0]), .ovr_clr(ovr_clr));

    uart_fifo_arbiter #(.CHANNELS(32), .DATA_W(10), .MIN_GAP(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_stb(req_stb), .req_data(req_data),
        .req_busy(busy[1]), .throttle(throttle), .fifo_cs(cs[1]),
        .fifo_data(fd[1]), .ovr_flags(ovr[1]), .ovr_clr(ovr_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: one held word per channel, a rotating priority start, a gap timer
    int         gap_of[2] = '{0, 3};
    logic       m_valid[2][32];
    logic [9:0] m_data[2][32];
    logic       m_ovr[2][32];
    logic [4:0] m_last[2];
    int         m_cnt[2];
    logic       m_cs[2];
    logic [31:0] m_fd[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 32; c++) begin
                    m_valid[d][c] = 1'b0;
                    m_ovr[d][c]   = 1'b0;
                    m_data[d][c]  = '0;
                end
                m_last[d] = 5'd31;
                m_cnt[d]  = 0;
                m_cs[d]   = 1'b0;
                m_fd[d]   = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin : step
                logic [4:0] ch, idx;
                bit found, go, gr, ov;
                found = 0;
                ch = '0;
                for (int k = 1; k <= 32; k++) begin
                    idx = 5'(int'(m_last[d]) + k);
                    if (!found && m_valid[d][idx]) begin
                        found = 1;
                        ch = idx;
                    end
                end
                go = found && !throttle && m_cnt[d] == 0;
                m_cs[d] = go;
                if (go) begin
                    m_fd[d]   = (32'(ch) << 10) | 32'(m_data[d][ch]);
                    m_last[d] = ch;
                    m_cnt[d]  = gap_of[d];
                end else if (m_cnt[d] > 0) begin
                    m_cnt[d] = m_cnt[d] - 1;
                end
                for (int c = 0; c < 32; c++) begin
                    gr = go && (ch == 5'(c));
                    ov = req_stb[c] && m_valid[d][c] && !gr;
                    if (ov) m_ovr[d][c] = 1'b1;
                    else if (ovr_clr[c]) m_ovr[d][c] = 1'b0;
                    if (req_stb[c] && !ov) begin
                        m_valid[d][c] = 1'b1;
                        m_data[d][c]  = req_data[c*10 +: 10];
                    end else if (gr) begin
                        m_valid[d][c] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [31:0] ev, eo;
            for (int c = 0; c < 32; c++) begin
                ev[c] = m_valid[d][c];
                eo[c] = m_ovr[d][c];
            end
            chk($sformatf("dut%0d fifo_cs", d), 32'(cs[d]), 32'(m_cs[d]));
            chk($sformatf("dut%0d req_busy", d), busy[d], ev);
            chk($sformatf("dut%0d ovr_flags", d), ovr[d], eo);
            if (m_cs[d])
                chk($sformatf("dut%0d fifo_data", d), fd[d], m_fd[d]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int gt[2][$];
        int gc[2][$];
        int seq[$];
        int words[$];
        int pos[$];
        int sent;

        rst_n = 1'b0; req_stb = '0; req_data = '0; throttle = 1'b0; ovr_clr = '0;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset fifo_cs", 32'(cs[d]), 32'h0);
            chk("reset fifo_data", fd[d], 32'h0);
            chk("reset req_busy", busy[d], 32'h0);
            chk("reset ovr_flags", ovr[d], 32'h0);
        end
        rst_n = 1'b1;
        tick();

        // single word on channel 0
        req_stb[0] = 1'b1; req_data[9:0] = 10'h05A;
        tick();
        req_stb = '0;
        for (int d = 0; d < 2; d++) chk("single busy", busy[d], 32'h1);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("single cs", 32'(cs[d]), 32'h1);
            chk("single data", fd[d], 32'h0000_005A);
            chk("single busy clr", busy[d], 32'h0);
        end
        tick();
        for (int d = 0; d < 2; d++) chk("single cs once", 32'(cs[d]), 32'h0);

        // full sweep twice: order 0..31 each time
        do_reset();
        for (int r = 0; r < 2; r++) begin
            req_stb = '1;
            for (int c = 0; c < 32; c++) req_data[c*10 +: 10] = 10'(c);
            tick();
            req_stb = '0;
            for (int k = 0; k < 32; k++) begin
                tick();
                chk("sweep cs", 32'(cs[0]), 32'h1);
                chk("sweep data", fd[0], 32'((k << 10) | k));
            end
        end
        for (int t = 0; t < 300 && busy[1] != 0; t++) tick();
        chk("sweep drain", busy[1], 32'h0);

        // channels 2 and 5 pending: gap spacing
        do_reset();
        req_stb = 32'h24;
        req_data[2*10 +: 10] = 10'h0C2;
        req_data[5*10 +: 10] = 10'h0C5;
        tick();
        req_stb = '0;
        for (int t = 0; t < 16; t++) begin
            tick();
            for (int d = 0; d < 2; d++)
                if (cs[d]) begin
                    gt[d].push_back(t);
                    gc[d].push_back(int'(fd[d][14:10]));
                end
        end
        for (int d = 0; d < 2; d++) begin
            chk("gap count", 32'(gc[d].size()), 32'd2);
            if (gc[d].size() == 2) begin
                chk("gap first ch", 32'(gc[d][0]), 32'd2);
                chk("gap second ch", 32'(gc[d][1]), 32'd5);
                chk("gap spacing", 32'(gt[d][1] - gt[d][0]), (d == 0) ? 32'd1 : 32'd4);
            end
        end

        // overrun on channel 7 under throttle
        do_reset();
        throttle = 1'b1;
        req_stb[7] = 1'b1; req_data[7*10 +: 10] = 10'h011;
        tick();
        req_data[7*10 +: 10] = 10'h022;
        tick();
        req_stb = '0;
        for (int d = 0; d < 2; d++) begin
            chk("ovr flag set", 32'(ovr[d][7]), 32'h1);
            chk("ovr held", busy[d], 32'h80);
        end
        tick(); tick();
        for (int d = 0; d < 2; d++) chk("throttle holds", 32'(cs[d]), 32'h0);
        throttle = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("ovr cs", 32'(cs[d]), 32'h1);
            chk("ovr data", fd[d], 32'h0000_1C11);
        end
        tick();
        for (int d = 0; d < 2; d++) chk("ovr no second", 32'(cs[d]), 32'h0);
        ovr_clr[7] = 1'b1;
        tick();
        ovr_clr = '0;
        for (int d = 0; d < 2; d++) chk("ovr clr", 32'(ovr[d][7]), 32'h0);

        // BREAK on channel 1 with channel 0 background
        do_reset();
        req_stb[1] = 1'b1; req_data[1*10 +: 10] = 10'h201; sent = 1;
        for (int t = 0; t < 16; t++) begin
            req_stb[0] = (t < 12);
            req_data[9:0] = 10'(10'h0A0 + t);
            tick();
            if (cs[0]) seq.push_back(int'(fd[0]));
            req_stb[1] = 1'b0;
            if (sent == 1 && !busy[0][1]) begin
                req_stb[1] = 1'b1; req_data[1*10 +: 10] = 10'h200; sent = 2;
            end
        end
        req_stb = '0;
        foreach (seq[j])
            if (seq[j][14:10] == 5'd1) begin
                words.push_back(seq[j]);
                pos.push_back(j);
            end
        chk("break count", 32'(words.size()), 32'd2);
        if (words.size() == 2) begin
            chk("break first", 32'(words[0]), 32'h0000_0601);
            chk("break second", 32'(words[1]), 32'h0000_0600);
            chk("break fair", 32'(pos[1] - pos[0]), 32'd2);
            chk("break lead", 32'(pos[0]), 32'd1);
        end

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            if (c >= 400 && c < 600)
                req_stb = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            else
                req_stb = $urandom & $urandom & $urandom;
            for (int k = 0; k < 32; k++) req_data[k*10 +: 10] = 10'($urandom);
            throttle = ($urandom_range(0, 7) == 0);
            ovr_clr = $urandom & $urandom & $urandom & $urandom;
            tick();
        end
        req_stb = '0; ovr_clr = '0;

        // reset with ten slots pending
        throttle = 1'b1;
        tick(); tick();
        req_stb = 32'h3FF;
        tick();
        req_stb = '0;
        for (int d = 0; d < 2; d++) chk("pend busy", busy[d] & 32'h3FF, 32'h3FF);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async cs", 32'(cs[d]), 32'h0);
            chk("async data", fd[d], 32'h0);
            chk("async busy", busy[d], 32'h0);
            chk("async ovr", ovr[d], 32'h0);
        end
        tick();
        rst_n = 1'b1;
        throttle = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            for (int d = 0; d < 2; d++) chk("post reset quiet", 32'(cs[d]), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_fifo_arbiter.md
# uart_fifo_arbiter

Round-robin arbiter that shares the single command port of `UARTS_Complex` (`fifo_cs` / `fifo_data`) among 32 per-channel requesters. Each channel has a one-word holding register. The arbiter grants at most one word per cycle onto the port and tags it with the 5-bit channel number. It throttles on the complex's semi-overflow status and records per-channel overruns. It replaces the wired-OR strobe bus used in simulation with a synthesizable mux.

## Interface
Parameters:
- `CHANNELS`, 32: number of requesters. Channel index width is fixed at 5 bits.
- `DATA_W`, 10: payload width. Bit `DATA_W-1` is the CONTROL flag; low bits are the control kind, with [0] = BREAK state.
- `MIN_GAP`, 0: idle cycles forced between consecutive grants (0..15).

Ports:
- `clk` in 1: the only clock. Same clock as `UARTS_Complex.clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_stb` in 32: per-channel write strobe, one cycle per word.
- `req_data` in 32*DATA_W: channel i payload at `[i*DATA_W +: DATA_W]`.
- `req_busy` out 32: holding register of channel i is occupied.
- `throttle` in 1: from `stat_semi_ovr`; while high, no new grant is issued.
- `fifo_cs` out 1: one-cycle write strobe to `UARTS_Complex`.
- `fifo_data` out 32: `{17'b0, ch[4:0], data[DATA_W-1:0]}`.
- `ovr_flags` out 32: sticky per-channel overrun flags.
- `ovr_clr` in 32: per-channel clear of `ovr_flags`.

## Operation
- Holding register per channel: a valid bit (which drives `req_busy`) and a data word.
  - When `req_stb[i]` arrives and the slot is empty, load the word and set valid.
  - When `req_stb[i]` arrives and the slot is full and not being granted this cycle, discard the word, set `ovr_flags[i]`, and leave the held word unchanged.
  - When `req_stb[i]` arrives in the same cycle that channel i is granted, accept the new word: valid stays 1 and the data is replaced.
- Round-robin pointer `last` (5 bits): search valid slots starting at `last+1`, with wrap-around modulo 32. The first valid slot found is granted, and `last` is set to that channel.
- Gap FSM, two states:
  - IDLE to GRANT: at least one valid slot, `throttle`=0, and gap counter = 0.
  - In GRANT, register `fifo_cs`=1 and `fifo_data`, clear the granted slot's valid bit, and load gap counter = `MIN_GAP`.
  - GRANT to IDLE every cycle. If `MIN_GAP`=0 and requests remain, it may return to GRANT directly, giving back-to-back grants.
  - Gap counter decrements to 0 while in IDLE.
- `throttle` is sampled in the decision cycle. When it is high, pending words stay held and `last` does not move.
- `ovr_flags[i]`: set has priority over `ovr_clr[i]` in the same cycle.
- Control words (MSB=1) are arbitrated exactly like data. Per-channel ordering is preserved by the single slot.

## Timing
- Reset values: `fifo_cs`=0, `fifo_data`=0, `req_busy`=0, `ovr_flags`=0, `last`=31 (so channel 0 wins first), gap counter=0, FSM=IDLE.
- Assertion of `rst_n` mid-operation discards all held words without emitting them. Deassertion is synchronized by the top-level reset block.
- Latency:
  - `req_stb` at edge N gives `req_busy`=1 after edge N.
  - Earliest `fifo_cs`=1 is after edge N+1, lasting exactly 1 cycle.
  - `req_busy` clears at the same edge that `fifo_cs` rises.
- Throughput:
  - One word per cycle when `MIN_GAP`=0.
  - Otherwise one word per `MIN_GAP+1` cycles.
  - Worst-case wait for a valid channel: 31 grants ahead of it.
- `throttle` going high at edge N: no `fifo_cs` after edge N+1. A grant already registered at edge N still completes.
- All outputs are registered. There is no combinational path from inputs to `fifo_cs`/`fifo_data`.

## Test plan
- Single word: `req_stb[0]`, `data`=0x05A → one `fifo_cs` 2 cycles later with `fifo_data`=0x0005A, and `req_busy[0]` pulses high for 1 cycle.
- All 32 channels strobe in one cycle with `data`=i → 32 consecutive `fifo_cs` pulses for channels 0,1,…,31 in order. Repeating the test gives the same order, because `last` is back at 31 after the sweep.
- `MIN_GAP`=3, channels 2 and 5 pending → grants 4 cycles apart, channel 2 first.
- Overrun: channel 7 strobes 0x011 and then 0x022 the next cycle while `throttle`=1 → `ovr_flags[7]`=1 and only 0x011 is sent after `throttle` drops. Pulsing `ovr_clr[7]` then clears the flag.
- BREAK sequence on channel 1: 0x201 then 0x200, plus background traffic on channel 0 → channel 1 words appear in order as `fifo_data` 0x0601 and 0x0600, and channel 0 alternates with channel 1 fairly.
- Assert `rst_n` low with 10 slots pending → all outputs return to 0 immediately, and no `fifo_cs` pulses after release until new requests arrive.
